// File: rtl/slow_domain_capture_pkg.sv
// ---------------------------------------------------------------------------
// slow_domain_capture_pkg
// Shared definitions for the slow-domain capture path.
//   DATA_W_DEF : default data width of captured words
//   clog2()    : ceiling log2, used to size FIFO pointers and the occupancy count
// ---------------------------------------------------------------------------
package slow_domain_capture_pkg;

    localparam int DATA_W_DEF = 32;

    // Smallest r such that (1 << r) >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/slow_domain_capture_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head word is always visible
// on rd_data_o; empty_o and count_o come straight from registers.
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-low (clears pointers and count)
//   push_i     in   write wr_data_i at the tail (caller guarantees room or pop)
//   pop_i      in   drop the head word (caller guarantees not empty)
//   wr_data_i  in   DATA_W word to write
//   rd_data_o  out  head-of-FIFO word (don't-care while empty)
//   count_o    out  occupancy, clog2(DEPTH)+1 bits
//   empty_o    out  count == 0
// ---------------------------------------------------------------------------
module sync_fifo
    import slow_domain_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic [clog2(DEPTH):0]     count_o,
    output logic                      empty_o
);

    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // DEPTH is a power of two, so natural pointer wrap is modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; when full with a simultaneous pop the
    // write lands in the slot being read, which is safe because the read is
    // taken from the pre-edge contents.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/slow_domain_capture.sv
// ---------------------------------------------------------------------------
// slow_domain_capture
// Fast-clock receiver for words produced in the divided-clock (sclk) domain.
// sclk comes from a clk-domain flop, so it is sampled directly without a
// synchroniser. Each sclk rising edge seen in the clk domain with s_valid high
// captures s_data into a small FIFO, presented downstream as valid/ready.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-low
//   sclk          in   divided clock (toggles on clk edges)
//   s_data        in   slow-domain data, stable while sclk is high
//   s_valid       in   qualifier for s_data
//   m_data        out  head-of-FIFO word
//   m_valid       out  FIFO not empty
//   m_ready       in   consumer accepts m_data
//   full          out  FIFO holds DEPTH words
//   overflow_cnt  out  saturating count of captures dropped while full
// ---------------------------------------------------------------------------
module slow_domain_capture
    import slow_domain_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2,
    parameter int OVF_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              full,
    output logic [OVF_W-1:0]  overflow_cnt
);

    localparam int CNT_W = clog2(DEPTH) + 1;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + OVF_W'(1);
    endfunction

    logic              sclk_q;
    logic              strobe;
    logic              cap_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [OVF_W-1:0]  ovf_q, ovf_d;

    // sclk_q resets high so an sclk that is already high at release does not
    // look like a fresh rising edge.
    assign strobe  = sclk & ~sclk_q;
    assign cap_req = strobe & s_valid;

    assign m_valid = ~fifo_empty;
    assign full    = (fifo_count == CNT_W'(DEPTH));
    assign pop     = m_valid & m_ready;

    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push    = cap_req & (~full | pop);
    assign drop    = cap_req & full & ~pop;

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = sat_inc(ovf_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_q <= 1'b1;
            ovf_q  <= '0;
        end else begin
            sclk_q <= sclk;
            ovf_q  <= ovf_d;
        end
    end

    assign overflow_cnt = ovf_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (s_data),
        .rd_data_o (m_data),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty)
    );

endmodule

// File: tb/tb_slow_domain_capture.sv
module tb_slow_domain_capture;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic [31:0] s_data;
    logic        s_valid;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        full;
    logic [1:0]  overflow_cnt;

    int n_chk;
    int n_pass;

    slow_domain_capture #(
        .DATA_W (32),
        .DEPTH  (2),
        .OVF_W  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .full         (full),
        .overflow_cnt (overflow_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sclk low/high cycle; the capture happens on the second clk edge.
    task automatic sedge(input logic [31:0] d);
        sclk    = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        tick();
        sclk = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst     = 1'b0;
        sclk    = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h99;
        m_ready = 1'b0;

        // 1. reset, release with sclk already high and s_valid asserted
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("t1_m_valid", {31'b0, m_valid}, 32'd0);
        chk("t1_full", {31'b0, full}, 32'd0);
        chk("t1_ovf", {30'b0, overflow_cnt}, 32'd0);
        s_valid = 1'b0;

        // 2. single capture, s_valid held while sclk stays high
        sclk    = 1'b0;
        s_data  = 32'hDEADBEEF;
        s_valid = 1'b1;
        tick();
        sclk = 1'b1;
        tick();
        chk("t2_m_valid", {31'b0, m_valid}, 32'd1);
        chk("t2_m_data", m_data, 32'hDEADBEEF);
        tick();
        tick();
        chk("t2_one_entry_full", {31'b0, full}, 32'd0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t2_drained", {31'b0, m_valid}, 32'd0);

        // 3. fill and overflow
        sedge(32'h1);
        chk("t3_not_full_1", {31'b0, full}, 32'd0);
        sedge(32'h2);
        chk("t3_full", {31'b0, full}, 32'd1);
        sedge(32'h3);
        sedge(32'h4);
        chk("t3_ovf", {30'b0, overflow_cnt}, 32'd2);
        chk("t3_head", m_data, 32'h1);
        m_ready = 1'b1;
        tick();
        chk("t3_second", m_data, 32'h2);
        chk("t3_second_valid", {31'b0, m_valid}, 32'd1);
        tick();
        m_ready = 1'b0;
        chk("t3_empty", {31'b0, m_valid}, 32'd0);
        chk("t3_not_full", {31'b0, full}, 32'd0);

        // 4. full with simultaneous push and pop
        sedge(32'hA);
        sedge(32'hB);
        chk("t4_full", {31'b0, full}, 32'd1);
        sclk = 1'b0;
        tick();
        sclk    = 1'b1;
        s_data  = 32'hC;
        s_valid = 1'b1;
        m_ready = 1'b1;
        chk("t4_head_a", m_data, 32'hA);
        tick();
        s_valid = 1'b0;
        chk("t4_head_b", m_data, 32'hB);
        chk("t4_still_full", {31'b0, full}, 32'd1);
        chk("t4_ovf_same", {30'b0, overflow_cnt}, 32'd2);
        tick();
        chk("t4_head_c", m_data, 32'hC);
        tick();
        chk("t4_empty", {31'b0, m_valid}, 32'd0);
        // empty with push and m_ready=1: word shows up, not popped that cycle
        sedge(32'h77);
        chk("t4_fwft_valid", {31'b0, m_valid}, 32'd1);
        chk("t4_fwft_data", m_data, 32'h77);
        tick();
        chk("t4_fwft_popped", {31'b0, m_valid}, 32'd0);
        m_ready = 1'b0;

        // 6. reset mid-stream with an in-flight strobe
        sedge(32'h11);
        sedge(32'h22);
        chk("t6_full_before", {31'b0, full}, 32'd1);
        sclk = 1'b0;
        tick();
        sclk    = 1'b1;
        s_data  = 32'h33;
        s_valid = 1'b1;
        rst     = 1'b0;
        tick();
        rst     = 1'b1;
        s_valid = 1'b0;
        chk("t6_m_valid", {31'b0, m_valid}, 32'd0);
        chk("t6_full", {31'b0, full}, 32'd0);
        chk("t6_ovf", {30'b0, overflow_cnt}, 32'd0);
        tick();
        chk("t6_no_strobe", {31'b0, m_valid}, 32'd0);
        sedge(32'h55);
        chk("t6_first_after", m_data, 32'h55);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t6_drained", {31'b0, m_valid}, 32'd0);

        // 5. saturation of the 2-bit overflow counter
        sedge(32'h5A);
        sedge(32'hA5);
        for (int i = 0; i < 3; i++) sedge(32'h100 + i);
        chk("t5_ovf_3", {30'b0, overflow_cnt}, 32'd3);
        for (int i = 0; i < 3; i++) sedge(32'h200 + i);
        chk("t5_ovf_sat", {30'b0, overflow_cnt}, 32'd3);
        chk("t5_head", m_data, 32'h5A);
        m_ready = 1'b1;
        tick();
        chk("t5_second", m_data, 32'hA5);
        tick();
        m_ready = 1'b0;
        chk("t5_empty", {31'b0, m_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
